// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: decode-stage immediate generator behind a valid/ready handshake.
// Immediate, format and legality are decoded at capture; SKID selects a 2-entry skid buffer.
module imm_gen_pipe #(
   parameter int XLEN = 32,
   parameter int SKID = 1
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_inst,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [31:0]     out_inst,
   output logic [XLEN-1:0] out_imm,
   output logic [2:0]      out_fmt,
   output logic            out_illegal
);

   localparam logic [2:0] FMT_R     = 3'd0;
   localparam logic [2:0] FMT_I     = 3'd1;
   localparam logic [2:0] FMT_S     = 3'd2;
   localparam logic [2:0] FMT_B     = 3'd3;
   localparam logic [2:0] FMT_U     = 3'd4;
   localparam logic [2:0] FMT_J     = 3'd5;
   localparam logic [2:0] FMT_SHAMT = 3'd6;
   localparam logic [2:0] FMT_NONE  = 3'd7;

   localparam logic [6:0] OPC_OP      = 7'b0110011;
   localparam logic [6:0] OPC_OP32    = 7'b0111011;
   localparam logic [6:0] OPC_LOAD    = 7'b0000011;
   localparam logic [6:0] OPC_JALR    = 7'b1100111;
   localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
   localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE   = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
   localparam logic [6:0] OPC_LUI     = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
   localparam logic [6:0] OPC_JAL     = 7'b1101111;

   localparam bit RV64 = (XLEN == 64);

   typedef struct packed {
      logic [31:0]     inst;
      logic [XLEN-1:0] imm;
      logic [2:0]      fmt;
      logic            illegal;
   } entry_t;

   localparam entry_t ENTRY_RESET = '{inst: 32'h0000_0000, imm: {XLEN{1'b0}},
                                      fmt: FMT_NONE, illegal: 1'b0};

   function automatic entry_t decode(input logic [31:0] inst);
      entry_t e;
      logic   is_shift;
      e.inst    = inst;
      e.imm     = {XLEN{1'b0}};
      e.fmt     = FMT_NONE;
      e.illegal = 1'b0;
      // funct3 001 (SLLI) or 101 (SRLI/SRAI); inst[30] never reaches imm
      is_shift  = (inst[13:12] == 2'b01);
      case (inst[6:0])
         OPC_OP: begin
            e.fmt = FMT_R;
         end
         OPC_OP32: begin
            if (RV64) begin
               e.fmt = FMT_R;
            end else begin
               e.illegal = 1'b1;
            end
         end
         OPC_LOAD, OPC_JALR: begin
            e.fmt = FMT_I;
            e.imm = XLEN'($signed(inst[31:20]));
         end
         OPC_OPIMM: begin
            if (is_shift) begin
               e.fmt = FMT_SHAMT;
               e.imm = RV64 ? XLEN'(inst[25:20]) : XLEN'(inst[24:20]);
            end else begin
               e.fmt = FMT_I;
               e.imm = XLEN'($signed(inst[31:20]));
            end
         end
         OPC_OPIMM32: begin
            if (!RV64) begin
               e.illegal = 1'b1;
            end else if (is_shift) begin
               e.fmt = FMT_SHAMT;
               e.imm = XLEN'(inst[24:20]);
            end else begin
               e.fmt = FMT_I;
               e.imm = XLEN'($signed(inst[31:20]));
            end
         end
         OPC_STORE: begin
            e.fmt = FMT_S;
            e.imm = XLEN'($signed({inst[31:25], inst[11:7]}));
         end
         OPC_BRANCH: begin
            e.fmt = FMT_B;
            e.imm = XLEN'($signed({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}));
         end
         OPC_LUI, OPC_AUIPC: begin
            e.fmt = FMT_U;
            e.imm = XLEN'($signed({inst[31:12], 12'h000}));
         end
         OPC_JAL: begin
            e.fmt = FMT_J;
            e.imm = XLEN'($signed({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}));
         end
         default: begin
            e.illegal = 1'b1;
         end
      endcase
      return e;
   endfunction

   entry_t main_r;
   entry_t main_n_s;
   logic   main_valid_r;
   logic   main_valid_n_s;
   entry_t in_entry_s;
   logic   accept_s;

   assign in_entry_s  = decode(in_inst);
   assign accept_s    = in_valid & in_ready;
   assign out_valid   = main_valid_r;
   assign out_inst    = main_r.inst;
   assign out_imm     = main_r.imm;
   assign out_fmt     = main_r.fmt;
   assign out_illegal = main_r.illegal;

   generate
      if (SKID != 0) begin : g_skid
         entry_t skid_r;
         entry_t skid_n_s;
         logic   skid_valid_r;
         logic   skid_valid_n_s;
         logic   in_ready_r;
         logic   main_free_s;

         assign main_free_s = ~main_valid_r | out_ready;
         assign in_ready    = in_ready_r;

         // Main/skid next state; skid drains into main before any new input is considered
         always_comb begin
            main_valid_n_s = main_valid_r;
            main_n_s       = main_r;
            skid_valid_n_s = skid_valid_r;
            skid_n_s       = skid_r;
            if (main_free_s) begin
               if (skid_valid_r) begin
                  main_valid_n_s = 1'b1;
                  main_n_s       = skid_r;
                  skid_valid_n_s = 1'b0;
               end else if (accept_s) begin
                  main_valid_n_s = 1'b1;
                  main_n_s       = in_entry_s;
               end else begin
                  main_valid_n_s = 1'b0;
               end
            end else if (accept_s) begin
               skid_valid_n_s = 1'b1;
               skid_n_s       = in_entry_s;
            end else begin
               skid_valid_n_s = skid_valid_r;
            end
         end

         // Skid register and the flopped in_ready that mirrors an empty skid slot
         always_ff @(posedge clk) begin
            if (rst || flush) begin
               skid_valid_r <= 1'b0;
               skid_r       <= ENTRY_RESET;
               in_ready_r   <= 1'b1;
            end else begin
               skid_valid_r <= skid_valid_n_s;
               skid_r       <= skid_n_s;
               in_ready_r   <= ~skid_valid_n_s;
            end
         end
      end else begin : g_noskid
         assign in_ready = out_ready | ~main_valid_r;

         // Single output register: load on accept, empty on an unreplaced output transfer
         always_comb begin
            main_valid_n_s = main_valid_r;
            main_n_s       = main_r;
            if (accept_s) begin
               main_valid_n_s = 1'b1;
               main_n_s       = in_entry_s;
            end else if (out_ready) begin
               main_valid_n_s = 1'b0;
            end else begin
               main_valid_n_s = main_valid_r;
            end
         end
      end
   endgenerate

   // Output register; reset and flush override any transfer on the same edge
   always_ff @(posedge clk) begin
      if (rst || flush) begin
         main_valid_r <= 1'b0;
         main_r       <= ENTRY_RESET;
      end else begin
         main_valid_r <= main_valid_n_s;
         main_r       <= main_n_s;
      end
   end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Scoreboard bench for imm_gen_pipe: XLEN=32/SKID=1 and XLEN=64/SKID=0 instances,
// directed vectors with hand-computed immediates checked by per-instance monitors.
module tb_imm_gen_pipe;

   typedef struct {
      logic [31:0] inst;
      logic [63:0] imm;
      logic [2:0]  fmt;
      logic        ill;
   } vec_t;

   logic        clk = 1'b0;
   logic        rst, flush;
   logic [31:0] in_inst;
   logic        in_valid32, in_ready32, out_ready32, out_valid32, out_illegal32;
   logic        in_valid64, in_ready64, out_ready64, out_valid64, out_illegal64;
   logic [31:0] out_inst32, out_inst64;
   logic [31:0] out_imm32;
   logic [63:0] out_imm64;
   logic [2:0]  out_fmt32, out_fmt64;

   int n_checks = 0;
   int n_fail   = 0;
   int pops32   = 0;
   vec_t q32[$];
   vec_t q64[$];

   always #5 clk = ~clk;

   imm_gen_pipe #(.XLEN(32), .SKID(1)) dut32 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid32), .in_ready(in_ready32), .in_inst(in_inst),
      .out_valid(out_valid32), .out_ready(out_ready32), .out_inst(out_inst32),
      .out_imm(out_imm32), .out_fmt(out_fmt32), .out_illegal(out_illegal32));

   imm_gen_pipe #(.XLEN(64), .SKID(0)) dut64 (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid64), .in_ready(in_ready64), .in_inst(in_inst),
      .out_valid(out_valid64), .out_ready(out_ready64), .out_inst(out_inst64),
      .out_imm(out_imm64), .out_fmt(out_fmt64), .out_illegal(out_illegal64));

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual %0h required %0h", name, act, exp);
      end
   endtask

   // Called on a negedge; returns on the negedge after the accepting posedge.
   task automatic send(input bit d64, input vec_t v);
      bit acc = 1'b0;
      int n   = 0;
      in_inst = v.inst;
      if (d64) in_valid64 = 1'b1; else in_valid32 = 1'b1;
      while (!acc && n < 50) begin
         #1;
         acc = d64 ? in_ready64 : in_ready32;
         @(posedge clk);
         if (acc) begin
            if (d64) q64.push_back(v); else q32.push_back(v);
         end
         @(negedge clk);
         n++;
      end
      in_valid32 = 1'b0;
      in_valid64 = 1'b0;
      chk("send_accepted", 128'(acc), 128'd1);
   endtask

   task automatic lat_check(input bit d64, input logic [31:0] inst);
      #1;
      chk(d64 ? "lat64_valid" : "lat32_valid", 128'(d64 ? out_valid64 : out_valid32), 128'd1);
      chk(d64 ? "lat64_inst" : "lat32_inst", 128'(d64 ? out_inst64 : out_inst32), 128'(inst));
   endtask

   task automatic reset_check(input string tag);
      chk({tag, "_valid32"}, 128'(out_valid32), 128'd0);
      chk({tag, "_fields32"}, {out_inst32, out_imm32, out_fmt32, out_illegal32}, {32'h0, 32'h0, 3'd7, 1'b0});
      chk({tag, "_ready32"}, 128'(in_ready32), 128'd1);
      chk({tag, "_valid64"}, 128'(out_valid64), 128'd0);
      chk({tag, "_fields64"}, {out_inst64, out_imm64, out_fmt64, out_illegal64}, {32'h0, 64'h0, 3'd7, 1'b0});
      chk({tag, "_ready64"}, 128'(in_ready64), 128'd1);
   endtask

   // Monitor for the 32-bit instance: pops on every output transfer, checks hold during stalls
   logic        stall32 = 1'b0;
   logic [67:0] held32;
   always @(negedge clk) begin
      vec_t e;
      #3;
      if (stall32 && out_valid32)
         chk("dut32_stable", 128'({out_inst32, out_imm32, out_fmt32, out_illegal32}), 128'(held32));
      stall32 = out_valid32 && !out_ready32 && !flush && !rst;
      held32  = {out_inst32, out_imm32, out_fmt32, out_illegal32};
      if (out_valid32 && out_ready32) begin
         pops32++;
         if (q32.size() == 0) begin
            chk("dut32_unexpected_out", 128'(out_inst32), 128'hDEAD);
         end else begin
            e = q32.pop_front();
            chk("dut32_inst", 128'(out_inst32), 128'(e.inst));
            chk("dut32_imm", 128'(out_imm32), 128'(e.imm[31:0]));
            chk("dut32_fmt_ill", 128'({out_fmt32, out_illegal32}), 128'({e.fmt, e.ill}));
         end
      end
   end

   // Monitor for the 64-bit instance
   logic        stall64 = 1'b0;
   logic [99:0] held64;
   always @(negedge clk) begin
      vec_t e;
      #3;
      if (stall64 && out_valid64)
         chk("dut64_stable", 128'({out_inst64, out_imm64, out_fmt64, out_illegal64}), 128'(held64));
      stall64 = out_valid64 && !out_ready64 && !flush && !rst;
      held64  = {out_inst64, out_imm64, out_fmt64, out_illegal64};
      if (out_valid64 && out_ready64) begin
         if (q64.size() == 0) begin
            chk("dut64_unexpected_out", 128'(out_inst64), 128'hDEAD);
         end else begin
            e = q64.pop_front();
            chk("dut64_inst", 128'(out_inst64), 128'(e.inst));
            chk("dut64_imm", 128'(out_imm64), 128'(e.imm));
            chk("dut64_fmt_ill", 128'({out_fmt64, out_illegal64}), 128'({e.fmt, e.ill}));
         end
      end
   end

   vec_t tab32 [15] = '{
      '{32'hFFF00093, 64'hFFFFFFFF, 3'd1, 1'b0},   // addi -1
      '{32'h12345037, 64'h12345000, 3'd4, 1'b0},   // lui
      '{32'hFE000CE3, 64'hFFFFFFF8, 3'd3, 1'b0},   // beq -8
      '{32'hFFDFF06F, 64'hFFFFFFFC, 3'd5, 1'b0},   // jal -4
      '{32'h4030D093, 64'h00000003, 3'd6, 1'b0},   // srai 3
      '{32'h0000007F, 64'h00000000, 3'd7, 1'b1},   // unknown opcode
      '{32'h0000003B, 64'h00000000, 3'd7, 1'b1},   // OP-32 illegal at RV32
      '{32'h0020A423, 64'h00000008, 3'd2, 1'b0},   // sw +8
      '{32'hFE20AE23, 64'hFFFFFFFC, 3'd2, 1'b0},   // sw -4
      '{32'h002081B3, 64'h00000000, 3'd0, 1'b0},   // add
      '{32'hFFFFF117, 64'hFFFFF000, 3'd4, 1'b0},   // auipc
      '{32'h02109093, 64'h00000001, 3'd6, 1'b0},   // inst[25] ignored at RV32
      '{32'h0210909B, 64'h00000000, 3'd7, 1'b1},   // OP-IMM-32 illegal at RV32
      '{32'hFFC08067, 64'hFFFFFFFC, 3'd1, 1'b0},   // jalr -4
      '{32'h7FF0A083, 64'h000007FF, 3'd1, 1'b0}    // lw +2047
   };

   vec_t tab64 [8] = '{
      '{32'h02109093, 64'h0000000000000021, 3'd6, 1'b0},   // slli 33
      '{32'h80000037, 64'hFFFFFFFF80000000, 3'd4, 1'b0},   // lui
      '{32'hFFF00093, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0},   // addi -1
      '{32'h0000003B, 64'h0000000000000000, 3'd0, 1'b0},   // OP-32
      '{32'h0210909B, 64'h0000000000000001, 3'd6, 1'b0},   // slliw: 5-bit shamt
      '{32'hFFF0009B, 64'hFFFFFFFFFFFFFFFF, 3'd1, 1'b0},   // addiw -1
      '{32'h0000007F, 64'h0000000000000000, 3'd7, 1'b1},   // unknown opcode
      '{32'hFE000CE3, 64'hFFFFFFFFFFFFFFF8, 3'd3, 1'b0}    // beq -8
   };

   initial begin
      #200000;
      $display("FAIL watchdog: actual timeout required finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int p0;
      rst = 1'b1; flush = 1'b0; in_inst = 32'h0;
      in_valid32 = 1'b0; in_valid64 = 1'b0; out_ready32 = 1'b1; out_ready64 = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      #1 reset_check("reset");
      @(negedge clk);

      // single-issue streams, one-cycle latency
      foreach (tab32[i]) begin
         send(1'b0, tab32[i]);
         lat_check(1'b0, tab32[i].inst);
      end
      foreach (tab64[i]) begin
         send(1'b1, tab64[i]);
         lat_check(1'b1, tab64[i].inst);
      end
      @(negedge clk);

      // SKID=1 back-pressure: two accepted, third held until release
      out_ready32 = 1'b0;
      send(1'b0, tab32[0]);
      send(1'b0, tab32[1]);
      in_inst = tab32[2].inst;
      in_valid32 = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 chk("bp32_in_ready_low", 128'(in_ready32), 128'd0);
         @(negedge clk);
      end
      out_ready32 = 1'b1;
      p0 = pops32;
      send(1'b0, tab32[2]);
      @(negedge clk);
      #4 chk("bp32_drain_rate", 128'(pops32 - p0), 128'd3);
      @(negedge clk);

      // SKID=0 back-pressure: combinational in_ready
      out_ready64 = 1'b0;
      send(1'b1, tab64[1]);
      #1 chk("bp64_in_ready_low", 128'(in_ready64), 128'd0);
      @(negedge clk);
      out_ready64 = 1'b1;
      #1 chk("bp64_in_ready_high", 128'(in_ready64), 128'd1);
      send(1'b1, tab64[4]);
      lat_check(1'b1, tab64[4].inst);
      @(negedge clk);

      // flush with main and skid full plus a concurrent input
      out_ready32 = 1'b0;
      send(1'b0, tab32[3]);
      send(1'b0, tab32[4]);
      in_inst = tab32[5].inst;
      in_valid32 = 1'b1;
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      in_valid32 = 1'b0;
      q32.delete();
      #1 chk("flush_valid", 128'(out_valid32), 128'd0);
      chk("flush_ready", 128'(in_ready32), 128'd1);
      chk("flush_fmt", 128'(out_fmt32), 128'd7);
      out_ready32 = 1'b1;
      repeat (4) @(negedge clk);

      // reset mid-stream with an input offered on the reset edge
      send(1'b0, tab32[7]);
      lat_check(1'b0, tab32[7].inst);
      rst = 1'b1;
      in_inst = tab32[8].inst;
      in_valid32 = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      in_valid32 = 1'b0;
      q32.delete();
      q64.delete();
      #1 reset_check("midreset");
      @(negedge clk);
      send(1'b0, tab32[10]);
      lat_check(1'b0, tab32[10].inst);

      repeat (5) @(negedge clk);
      chk("q32_empty", 128'(q32.size()), 128'd0);
      chk("q64_empty", 128'(q64.size()), 128'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Next-generation immediate generator for the decode stage. Registered and handshaked.
- Covers the full RV32I/RV64I immediate set: I, S, B, U, J, and shift-amount forms. Adds format classification and illegal-opcode flagging.
- XLEN-parametrised. Sits between instruction fetch and the register-read/execute stages.
- Uses a valid/ready interface with an optional skid buffer, so fetch is never back-pressured combinationally.

Parameters:
- XLEN, 32, datapath width; legal values 32 or 64. Instruction word is always 32 bits.
- SKID, 1, 1 = 2-entry skid buffer with registered in_ready; 0 = single output register with combinational in_ready.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- flush  input  1  synchronous pipeline flush (branch redirect).
- in_valid  input  1  instruction present on in_inst.
- in_ready  output  1  block can accept in_inst this cycle.
- in_inst  input  32  instruction word.
- out_valid  output  1  out_* fields hold a decoded instruction.
- out_ready  input  1  downstream accepts out_* this cycle.
- out_inst  output  32  instruction passthrough.
- out_imm  output  XLEN  sign/zero-extended immediate.
- out_fmt  output  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J, 6=SHAMT, 7=NONE.
- out_illegal  output  1  opcode not supported.

Behaviour:
- Reset and flush: both clear all entries. out_valid=0, out_imm=0, out_inst=0, out_fmt=7, out_illegal=0. in_ready=1 on the following cycle.
- A transfer occurs when valid&ready on the same edge.
- Latency: an accepted instruction appears on out_* exactly 1 cycle later, provided the output slot is free.
- Output stability: while out_valid=1 and out_ready=0, all out_* hold their values.
- Ordering: strict FIFO. No drop or duplicate except on flush.
- SKID=0 mode:
  - in_ready = out_ready | ~out_valid.
  - Output register loads on accept.
  - out_valid clears on an output transfer with no simultaneous input.
- SKID=1 mode:
  - Uses a main register and a skid register.
  - in_ready = ~skid_valid, driven from a flop.
  - An input accepted while main is stalled goes to skid.
  - When main drains, skid moves to main in the same edge. A new input accepted that edge goes to skid only if main is still occupied.
  - Full throughput (1 per cycle) when out_ready stays 1.
- Flush and rst have priority over everything, including a simultaneous in_valid & in_ready. That input is dropped. Flush mid-stall discards both entries.
- Decode (computed at capture; all sign extension is to XLEN):
  - 0110011 OP, and 0111011 OP-32 (XLEN=64 only): imm=0, fmt=R.
  - 0000011 LOAD, 1100111 JALR, 0010011 OP-IMM, 0011011 OP-IMM-32 (XLEN=64 only):
    - Default: imm = sext(inst[31:20]), fmt=I.
    - Shift case: funct3 001 or 101 under OP-IMM/OP-IMM-32 gives fmt=SHAMT, imm = zext of the shift amount. Shift amount is inst[24:20], or inst[25:20] when XLEN=64 and opcode=0010011. inst[30] (SRAI) does not affect imm.
  - 0100011 STORE: imm = sext({inst[31:25], inst[11:7]}), fmt=S.
  - 1100011 BRANCH: imm = sext({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), fmt=B.
  - 0110111 LUI, 0010111 AUIPC: imm = sext({inst[31:12], 12'b0}), fmt=U.
  - 1101111 JAL: imm = sext({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), fmt=J.
  - Any other opcode, including OP-32/OP-IMM-32 when XLEN=32: imm=0, fmt=NONE, illegal=1. Such instructions still pass through the handshake normally.
- No internal error state. Illegal instructions never stall the block.

Test Plan:
- XLEN=32, single-issue, out_ready=1:
  - 0xFFF00093 (addi) -> next cycle out_imm=0xFFFFFFFF, fmt=1.
  - 0x12345037 (lui) -> 0x12345000, fmt=4.
  - 0xFE000CE3 (beq -8) -> 0xFFFFFFF8, fmt=3.
  - 0xFFDFF06F (jal -4) -> 0xFFFFFFFC, fmt=5.
- Shifts: 0x4030D093 (srai 3) at XLEN=32 -> imm=3, fmt=6. 0x02109093 (slli 33) at XLEN=64 -> imm=0x21. XLEN=64 lui 0x80000037 -> 0xFFFFFFFF80000000.
- Illegal: 0x0000007F -> out_illegal=1, fmt=7, imm=0, out_valid=1 after 1 cycle, no stall.
- Back-pressure (SKID=1):
  - Stimulus: out_ready=0, stream 3 instructions.
  - Required: first two accepted; in_ready=0 on the cycle after the second accept; third held.
  - After releasing out_ready=1: outputs emerge in order, one per cycle, with out_* stable throughout the stall.
- Flush with both entries full plus in_valid=1 that cycle -> next cycle out_valid=0, in_ready=1, nothing later emerges from the dropped instructions.
- Reset asserted mid-stream for 1 cycle -> all outputs at reset values next cycle. The first post-reset instruction emerges with 1-cycle latency.
